cp0_unit: RTL and testbench

- Coprocessor-0 exception/interrupt unit. It sits directly downstream of the timer and consumes its IRQ on HWInt[2].
- Holds the SR, Cause, EPC and PRId registers, which the pipeline reads and writes via mfc0/mtc0.
- Raises IntReq to the pipeline when an unmasked hardware interrupt or a synchronous exception must be taken. Supplies EPC for eret.

---
 rtl/cp0_unit.sv | 118 +++++++++++
 tb/tb_cp0_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor-0 exception/interrupt unit.
// Holds SR, Cause, EPC and PRId. Raises IntReq for unmasked hardware interrupts
// or synchronous exceptions, and supplies EPC for eret.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   addr, WE        - CP0 register number and mtc0 write enable
//   DATA_in         - mtc0 write data
//   DATA_out        - mfc0 read data (combinational from addr, pre-write value)
//   PC, BD_in       - commit-stage PC and its branch-delay-slot flag
//   ExcCode_in      - synchronous exception code, 0 = none
//   HWInt           - hardware interrupt lines [7:2] (bit 0 here = timer IRQ)
//   EXLClr          - eret commit, clears SR.EXL
//   IntReq          - take interrupt/exception this cycle (combinational)
//   EPC             - current EPC register value
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h1919_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  addr,
  input  logic        WE,
  input  logic [31:0] DATA_in,
  output logic [31:0] DATA_out,
  input  logic [31:0] PC,
  input  logic        BD_in,
  input  logic [4:0]  ExcCode_in,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC
);

  localparam int unsigned DW = 32;
  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;
  localparam logic [DW-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic [5:0]    im;
  logic          exl;
  logic          ie;
  logic          bd;
  logic [5:0]    ip;
  logic [4:0]    exc_code;
  logic [DW-1:0] epc_q;

  logic          irq;
  logic          exc;
  logic [DW-1:0] epc_target;
  logic [DW-1:0] sr_word;
  logic [DW-1:0] cause_word;

  // Interrupt/exception request; forced low while reset is held.
  always_comb begin
    irq    = (|(HWInt & im)) & ie & ~exl;
    exc    = (ExcCode_in != 5'd0) & ~exl;
    IntReq = (irq | exc) & reset;
  end

  // Return address: back up to the branch when faulting in a delay slot.
  always_comb begin
    epc_target = (BD_in ? (PC - DW'(4)) : PC) & ALIGN_MASK;
  end

  // Architectural views of SR and Cause; unimplemented bits read 0.
  always_comb begin
    sr_word    = {16'd0, im, 8'd0, exl, ie};
    cause_word = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
  end

  // mfc0 read mux (no write-through bypass).
  always_comb begin
    DATA_out = '0;
    case (addr)
      ADDR_SR:    DATA_out = sr_word;
      ADDR_CAUSE: DATA_out = cause_word;
      ADDR_EPC:   DATA_out = epc_q;
      ADDR_PRID:  DATA_out = PRID;
      default:    DATA_out = '0;
    endcase
  end

  assign EPC = epc_q;

  // Register updates: exception entry takes precedence over mtc0/eret.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc_q    <= '0;
    end else begin
      ip <= HWInt;
      if (IntReq) begin
        exl      <= 1'b1;
        bd       <= BD_in;
        exc_code <= irq ? 5'd0 : ExcCode_in;
        epc_q    <= epc_target;
      end else begin
        if (WE && (addr == ADDR_SR)) begin
          im  <= DATA_in[15:10];
          ie  <= DATA_in[0];
          exl <= DATA_in[1] & ~EXLClr;
        end else if (EXLClr) begin
          exl <= 1'b0;
        end
        if (WE && (addr == ADDR_EPC)) begin
          epc_q <= DATA_in & ALIGN_MASK;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: a driver applies stimulus on the falling edge
// and queues the expected outputs from a word-level model; a monitor pops and
// compares them shortly afterwards.
module tb_cp0_unit;

  localparam logic [31:0] PRID_V  = 32'h1919_0001;
  localparam logic [31:0] SR_MASK = 32'h0000_FC03;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  addr;
  logic        WE;
  logic [31:0] DATA_in;
  logic [31:0] DATA_out;
  logic [31:0] PC;
  logic        BD_in;
  logic [4:0]  ExcCode_in;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC;

  cp0_unit dut (
    .clk(clk), .reset(reset), .addr(addr), .WE(WE), .DATA_in(DATA_in),
    .DATA_out(DATA_out), .PC(PC), .BD_in(BD_in), .ExcCode_in(ExcCode_in),
    .HWInt(HWInt), .EXLClr(EXLClr), .IntReq(IntReq), .EPC(EPC)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] dout;
    logic        req;
    logic [31:0] epc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   step_id = 0;

  // Model state as whole architectural words.
  logic [31:0] m_sr = 0, m_cause = 0, m_epc = 0;

  task automatic step(input logic rst, input logic [4:0] a, input logic we,
                      input logic [31:0] din, input logic [31:0] pc, input logic bd,
                      input logic [4:0] ec, input logic [5:0] hw, input logic clr);
    exp_t e;
    logic exl, irq, exc, req;
    @(negedge clk);
    reset = rst; addr = a; WE = we; DATA_in = din; PC = pc; BD_in = bd;
    ExcCode_in = ec; HWInt = hw; EXLClr = clr;
    if (!rst) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end
    exl = m_sr[1];
    irq = ((hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !exl;
    exc = (ec != 5'd0) && !exl;
    req = rst && (irq || exc);
    e.id  = step_id;
    e.req = req;
    e.epc = m_epc;
    case (a)
      5'd12:   e.dout = m_sr;
      5'd13:   e.dout = m_cause;
      5'd14:   e.dout = m_epc;
      5'd15:   e.dout = PRID_V;
      default: e.dout = 32'd0;
    endcase
    q.push_back(e);
    step_id++;
    if (rst) begin
      m_cause = (m_cause & ~32'h0000_FC00) | (32'(hw) << 10);
      if (req) begin
        m_sr    = m_sr | 32'd2;
        m_cause = (m_cause & 32'h0000_FC00) | (bd ? 32'h8000_0000 : 32'd0)
                  | (irq ? 32'd0 : (32'(ec) << 2));
        m_epc   = (bd ? pc - 32'd4 : pc) & 32'hFFFF_FFFC;
      end else begin
        if (we && a == 5'd12) m_sr = din & SR_MASK;
        if (clr) m_sr = m_sr & ~32'd2;
        if (we && a == 5'd14) m_epc = din & 32'hFFFF_FFFC;
      end
    end
  endtask

  // Monitor: compare every presented output against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (DATA_out !== e.dout) begin
          errors++;
          $display("FAIL step%0d data_out: got %h expected %h", e.id, DATA_out, e.dout);
        end
        checks++;
        if (IntReq !== e.req) begin
          errors++;
          $display("FAIL step%0d intreq: got %b expected %b", e.id, IntReq, e.req);
        end
        checks++;
        if (EPC !== e.epc) begin
          errors++;
          $display("FAIL step%0d epc: got %h expected %h", e.id, EPC, e.epc);
        end
      end
    end
  end

  initial begin
    logic [4:0]  ra;
    logic [5:0]  rh;
    logic [4:0]  re;
    logic [31:0] rd;
    int          wait_cyc;
    reset = 1'b0; addr = 0; WE = 0; DATA_in = 0; PC = 0; BD_in = 0;
    ExcCode_in = 0; HWInt = 0; EXLClr = 0;

    // Reset, enable IM[2]+IE, timer interrupt.
    step(0, 12, 0, 0, 0, 0, 0, 6'd0, 0);
    step(1, 12, 1, 32'h0000_0401, 0, 0, 0, 6'd0, 0);
    step(1, 12, 0, 0, 32'h0000_3010, 0, 0, 6'b000001, 0);
    step(1, 13, 0, 0, 32'h0000_3014, 0, 0, 6'b000001, 0);
    step(1, 12, 0, 0, 32'h0000_3018, 0, 0, 6'b000001, 0);
    // Masked: IE=0, toggle timer line, watch IP.
    step(0, 13, 0, 0, 0, 0, 0, 6'd0, 0);
    step(1, 12, 1, 32'h0000_0400, 0, 0, 0, 6'd0, 0);
    step(1, 13, 0, 0, 0, 0, 0, 6'b000001, 0);
    step(1, 13, 0, 0, 0, 0, 0, 6'b000000, 0);
    step(1, 13, 0, 0, 0, 0, 0, 6'b000001, 0);
    step(1, 13, 0, 0, 0, 0, 0, 6'b000000, 0);
    // Synchronous exception in a delay slot.
    step(1, 13, 0, 0, 32'h0000_3024, 1, 5'd10, 6'd0, 0);
    step(1, 13, 0, 0, 0, 0, 0, 6'd0, 0);
    step(1, 14, 0, 0, 0, 0, 0, 6'd0, 0);
    // Interrupt + exception + EPC write together.
    step(0, 12, 0, 0, 0, 0, 0, 6'd0, 0);
    step(1, 12, 1, 32'h0000_0401, 0, 0, 0, 6'd0, 0);
    step(1, 14, 1, 32'h1234_5678, 32'h0000_4008, 0, 5'd4, 6'b000001, 0);
    step(1, 13, 0, 0, 0, 0, 0, 6'b000001, 0);
    // eret with line still high: re-entry next cycle.
    step(1, 12, 0, 0, 32'h0000_5000, 0, 0, 6'b000001, 1);
    step(1, 12, 0, 0, 32'h0000_5004, 0, 0, 6'b000001, 0);
    step(1, 15, 0, 0, 0, 0, 0, 6'b000001, 0);
    step(1, 7, 0, 0, 0, 0, 0, 6'b000001, 0);
    // SR write together with EXLClr: EXL ends 0.
    step(1, 12, 1, 32'h0000_0003, 0, 0, 0, 6'd0, 1);
    step(1, 12, 0, 0, 0, 0, 0, 6'd0, 0);
    // Reset mid-handler, no clock edge needed.
    step(0, 14, 0, 0, 0, 0, 0, 6'b000001, 0);
    step(0, 12, 0, 0, 0, 0, 0, 6'b000001, 0);
    step(0, 13, 0, 0, 0, 0, 0, 6'b000001, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: ra = 5'd12;
        1: ra = 5'd13;
        2: ra = 5'd14;
        3: ra = 5'd15;
        default: ra = 5'($urandom);
      endcase
      rh = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      re = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'd0;
      rd = $urandom;
      if ($urandom_range(0, 2) == 0) rd[0] = 1'b1;
      step(($urandom_range(0, 49) != 0), ra, ($urandom_range(0, 2) == 0), rd,
           $urandom, 1'($urandom), re, rh, ($urandom_range(0, 5) == 0));
    end

    // Drain the scoreboard with a bounded wait.
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
